// File: rtl/h80bus_master_if.sv
// h80 bus master interface: requester handshake plus the bus control/address lines.
// data_ is bidirectional and travels as a plain inout port on the master.
interface h80bus_master_if #(
  parameter int AW = 16,
  parameter int CW = 3,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] req_cmd;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ce_n;
  logic [AW-1:0] addr;
  logic [CW-1:0] cmd;
  logic          wait_n;

  modport master (
    input  req_valid, req_addr, req_cmd, req_wdata, wait_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ce_n, addr, cmd
  );

  modport slave (
    output req_valid, req_addr, req_cmd, req_wdata, wait_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ce_n, addr, cmd
  );
endinterface

// File: rtl/h80bus_master.sv
// h80 bus master: converts one valid/ready request into a single bus access,
// stretched by wait_n, bounded by a timeout, followed by one turnaround cycle.
module h80bus_master #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 16,
  parameter int MIN_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  h80bus_master_if.master           bus,
  inout  wire  [BUS_DATA_WIDTH-1:0] io_data_
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_req_ready;
  logic                      r_rsp_valid;
  logic [BUS_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;
  logic                      r_ce_n;
  logic [BUS_ADDR_WIDTH-1:0] r_addr;
  logic [BUS_CMD_WIDTH-1:0]  r_cmd;
  logic [BUS_DATA_WIDTH-1:0] r_wdata;
  logic                      w_accept;
  logic                      w_done;
  logic                      w_drive;

  // A request is taken only when it meets a registered ready.
  assign w_accept = bus.req_valid && r_req_ready;
  // Completion needs the minimum hold time and a ready responder.
  assign w_done   = (r_cnt >= CNT_W'(MIN_CYCLES)) && bus.wait_n;
  // Master owns data_ only during a write access; reads and idle release it.
  assign w_drive  = !r_ce_n && !r_cmd[0];

  assign io_data_      = w_drive ? r_wdata : {BUS_DATA_WIDTH{1'bz}};
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.ce_n      = r_ce_n;
  assign bus.addr      = r_addr;
  assign bus.cmd       = r_cmd;

  // Access sequencer: IDLE accepts, ACCESS holds the bus, TURN idles the bus one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_ce_n      <= 1'b1;
      r_addr      <= '0;
      r_cmd       <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_addr      <= bus.req_addr;
            r_cmd       <= bus.req_cmd;
            r_wdata     <= bus.req_wdata;
            r_ce_n      <= 1'b0;
            r_cnt       <= CNT_W'(1);
            r_req_ready <= 1'b0;
            r_state     <= ACCESS;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ACCESS: begin
          r_req_ready <= 1'b0;
          if (w_done) begin
            r_rsp_rdata <= r_cmd[0] ? io_data_ : '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_ce_n      <= 1'b1;
            r_state     <= TURN;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_ce_n      <= 1'b1;
            r_state     <= TURN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TURN: begin
          // Ready rises here so IDLE can accept on its first edge.
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_ce_n  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
